// File: rtl/restoring_divider8.sv
// 8-bit unsigned restoring divider, one quotient bit per cycle.
// Three-state FSM: IDLE -> CALC (8 cycles) -> DONE.
module restoring_divider8 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       run_i,
    input  logic [7:0] dividend_i,
    input  logic [7:0] divisor_i,
    output logic [7:0] quotient_o,
    output logic [7:0] remainder_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       div_by_zero_o
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  p_q, p_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  quo_q, quo_d;
    logic [7:0]  rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic [8:0]  p_sh;
    logic [7:0]  q_sh;
    logic [8:0]  trial;
    logic [8:0]  p_nx;
    logic [7:0]  q_nx;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Trial subtraction as P + ~{0,D} + 1; bit 8 set means negative.
    always_comb begin
        p_sh  = {p_q[7:0], q_q[7]};
        q_sh  = {q_q[6:0], 1'b0};
        trial = p_sh + {1'b1, ~d_q} + 9'd1;
        if (!trial[8]) begin
            p_nx = trial;
            q_nx = q_sh | 8'd1;
        end else begin
            p_nx = p_sh;
            q_nx = q_sh;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (run_i) begin
                    q_d     = dividend_i;
                    d_d     = divisor_i;
                    p_d     = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d   = p_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    quo_d   = q_nx;
                    rem_d   = p_nx[7:0];
                    dbz_d   = (d_q == 8'd0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!run_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign busy_o        = (state_q == CALC);
    assign done_o        = (state_q == DONE);
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider8.sv
// Directed and randomised checks for restoring_divider8.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_restoring_divider8;

    logic       clk;
    logic       reset;
    logic       run;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    int checks   = 0;
    int failures = 0;

    restoring_divider8 dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .run_i         (run),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse Run for one cycle, then verify latency and results.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic ez);
        int bc;
        int n;
        bit seen;
        bit both;
        dividend = a;
        divisor  = b;
        run      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run  = 1'b0;
        bc   = 0;
        n    = 0;
        seen = 1'b0;
        both = 1'b0;
        while (!seen && n < 20) begin
            if (busy && done) both = 1'b1;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) bc++;
                n++;
                @(negedge clk);
            end
        end
        chk("busy_cycles", 16'(bc), 16'd8);
        chk("done_seen", {15'd0, seen}, 16'd1);
        chk("busy_done_overlap", {15'd0, both}, 16'd0);
        chk("quotient", {8'd0, quotient}, {8'd0, eq});
        chk("remainder", {8'd0, remainder}, {8'd0, er});
        chk("div_by_zero", {15'd0, dbz}, {15'd0, ez});
        @(negedge clk);
        chk("idle_done", {15'd0, done}, 16'd0);
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("idle_hold_q", {8'd0, quotient}, {8'd0, eq});
    endtask

    initial begin
        int bc;
        logic [7:0] a;
        logic [7:0] b;
        reset    = 1'b1;
        run      = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_quotient", {8'd0, quotient}, 16'd0);
        chk("rst_remainder", {8'd0, remainder}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_dbz", {15'd0, dbz}, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        run_div(8'd13, 8'd0, 8'hFF, 8'd13, 1'b1);
        run_div(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
        run_div(8'd128, 8'd2, 8'd64, 8'd0, 1'b0);
        run_div(8'd254, 8'd255, 8'd0, 8'd254, 1'b0);

        // Abort on the 4th CALC cycle.
        dividend = 8'd200;
        divisor  = 8'd7;
        run      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_quotient", {8'd0, quotient}, 16'd0);
        chk("abort_remainder", {8'd0, remainder}, 16'd0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_dbz", {15'd0, dbz}, 16'd0);
        reset = 1'b0;
        run_div(8'd100, 8'd3, 8'd33, 8'd1, 1'b0);

        // Held Run: one division only, operand changes ignored.
        dividend = 8'd50;
        divisor  = 8'd6;
        run      = 1'b1;
        bc       = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) bc++;
            if (i == 2) begin
                dividend = 8'd255;
                divisor  = 8'd1;
            end
        end
        chk("hold_busy_cycles", 16'(bc), 16'd8);
        chk("hold_done", {15'd0, done}, 16'd1);
        chk("hold_quotient", {8'd0, quotient}, 16'd8);
        chk("hold_remainder", {8'd0, remainder}, 16'd2);
        run = 1'b0;
        @(negedge clk);
        chk("hold_release_done", {15'd0, done}, 16'd0);
        chk("hold_release_busy", {15'd0, busy}, 16'd0);

        // Random operand sample against a reference model.
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (b == 8'd0)
                run_div(a, b, 8'hFF, a, 1'b1);
            else
                run_div(a, b, a / b, a % b, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
